// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops that act as D, T, JK or SR registers, or as an up/down counter with a wrap pulse.
// Define FFBANK_SR_ERR_EN to make err a sticky flag for SR set/reset conflicts; otherwise err is tied to 0.
module multi_mode_ff_bank #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_D    = 3'b001,
        MODE_T    = 3'b010,
        MODE_JK   = 3'b011,
        MODE_SR   = 3'b100,
        MODE_UP   = 3'b101,
        MODE_DOWN = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic             wrap;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        case (mode_sel)
            MODE_D:  q_next = a;
            MODE_T:  q_next = q ^ a;
            // JK per bit: 10 set, 11 toggle, 00 hold, 01 clear
            MODE_JK: q_next = (a & ~b) | (a & b & ~q) | (~a & ~b & q);
            // SR per bit: 10 set, 01 clear, 00 and 11 both hold
            MODE_SR: q_next = (a & ~b) | (q & ~(a ^ b));
            MODE_UP: begin
                if (q >= MAX_Q) begin
                    q_next = '0;
                    wrap   = 1'b1;
                end else begin
                    q_next = q + 1'b1;
                end
            end
            MODE_DOWN: begin
                if (q == '0) begin
                    q_next = MAX_Q;
                    wrap   = 1'b1;
                end else begin
                    q_next = q - 1'b1;
                end
            end
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q  <= '0;
            tc <= 1'b0;
        end else if (en) begin
            q  <= q_next;
            tc <= wrap;
        end else begin
            tc <= 1'b0;
        end
    end

`ifdef FFBANK_SR_ERR_EN
    logic sr_conflict;

    assign sr_conflict = (mode_sel == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (en && sr_conflict) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank with WIDTH=8, MAX_COUNT=9: vector table plus counting sequences.
module tb_multi_mode_ff_bank;

    localparam int WIDTH = 8;
`ifdef FFBANK_SR_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct {
        logic             reset;
        logic             en;
        logic [2:0]       mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_q;
        logic             exp_tc;
        logic             exp_err;
        string            name;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_tc_q[$];

    multi_mode_ff_bank #(.WIDTH(WIDTH), .MAX_COUNT(9)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .a(a), .b(b), .q(q), .tc(tc), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drive one edge, then sample 1 time unit after it
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        reset = r; en = e; mode = m; a = av; b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic [2:0] m,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] eq, input logic et, input logic ee,
                       input string nm);
        vec_t v;
        v.reset = r; v.en = e; v.mode = m; v.a = av; v.b = bv;
        v.exp_q = eq; v.exp_tc = et; v.exp_err = ee; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0,      "reset");
        add(0, 1, 3'b001, 8'h55, 8'h00, 8'h55, 0, 0,      "d_load");
        add(0, 1, 3'b010, 8'hFF, 8'h00, 8'hAA, 0, 0,      "t_all");
        add(0, 1, 3'b111, 8'hFF, 8'hFF, 8'hAA, 0, 0,      "reserved");
        add(0, 1, 3'b000, 8'h12, 8'h34, 8'hAA, 0, 0,      "hold");
        add(0, 1, 3'b001, 8'hF0, 8'h00, 8'hF0, 0, 0,      "d_f0");
        add(0, 1, 3'b011, 8'h3C, 8'h5A, 8'hAC, 0, 0,      "jk_mix");
        add(0, 1, 3'b100, 8'h0F, 8'hF0, 8'h0F, 0, 0,      "sr_set_clr");
        add(0, 1, 3'b100, 8'h30, 8'h03, 8'h3C, 0, 0,      "sr_mix");
        add(0, 0, 3'b001, 8'h00, 8'h00, 8'h3C, 0, 0,      "en_low");
        add(0, 1, 3'b100, 8'h01, 8'h01, 8'h3C, 0, ERR_ON, "sr_conflict");
        add(0, 1, 3'b100, 8'h80, 8'h00, 8'hBC, 0, ERR_ON, "sr_sticky");
        add(0, 0, 3'b000, 8'h00, 8'h00, 8'hBC, 0, ERR_ON, "err_hold_en0");
        add(1, 1, 3'b100, 8'h01, 8'h01, 8'h00, 0, 0,      "reset_in_conflict");
        add(0, 1, 3'b001, 8'h00, 8'h00, 8'h00, 0, 0,      "d_zero");
        add(0, 1, 3'b110, 8'h00, 8'h00, 8'h09, 1, 0,      "down_wrap");
        add(0, 1, 3'b110, 8'h00, 8'h00, 8'h08, 0, 0,      "down_dec");
        add(0, 1, 3'b001, 8'h20, 8'h00, 8'h20, 0, 0,      "d_above_max");
        add(0, 1, 3'b110, 8'h00, 8'h00, 8'h1F, 0, 0,      "down_above_max");
        add(0, 1, 3'b101, 8'h00, 8'h00, 8'h00, 1, 0,      "up_above_max");
        add(0, 1, 3'b001, 8'hFF, 8'h00, 8'hFF, 0, 0,      "d_ff");
        add(0, 1, 3'b010, 8'h0F, 8'h00, 8'hF0, 0, 0,      "t_low_nibble");

        foreach (vecs[i]) begin
            step(vecs[i].reset, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_q"}, 32'(q), 32'(vecs[i].exp_q));
            check({vecs[i].name, "_tc"}, 32'(tc), 32'(vecs[i].exp_tc));
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
        end

        // up count from reset: 1..9, 0, 1, 2 with tc only after 9->0
        step(1, 0, 3'b000, 8'h00, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            exp_q.push_back(WIDTH'(i % 10));
            exp_tc_q.push_back(i == 10);
        end
        while (exp_q.size() > 0) begin
            logic [WIDTH-1:0] eq;
            logic             et;
            eq = exp_q.pop_front();
            et = exp_tc_q.pop_front();
            step(0, 1, 3'b101, 8'h00, 8'h00);
            check("up_seq_q", 32'(q), 32'(eq));
            check("up_seq_tc", 32'(tc), 32'(et));
        end

        // freeze mid-count for three edges
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'b101, 8'h00, 8'h00);
            check("freeze_q", 32'(q), 32'(8'h02));
            check("freeze_tc", 32'(tc), 32'(1'b0));
        end

        // wrap then immediately disable: tc must drop
        step(0, 1, 3'b001, 8'h09, 8'h00);
        step(0, 1, 3'b101, 8'h00, 8'h00);
        check("wrap_q", 32'(q), 32'(8'h00));
        check("wrap_tc", 32'(tc), 32'(1'b1));
        step(0, 0, 3'b101, 8'h00, 8'h00);
        check("wrap_en0_tc", 32'(tc), 32'(1'b0));
        check("wrap_en0_q", 32'(q), 32'(8'h00));

        // reset overrides an enabled toggle-all
        step(0, 1, 3'b101, 8'h00, 8'h00);
        step(0, 1, 3'b101, 8'h00, 8'h00);
        check("pre_reset_q", 32'(q), 32'(8'h02));
        step(1, 1, 3'b010, 8'hFF, 8'h00);
        check("reset_override_q", 32'(q), 32'(8'h00));
        check("reset_override_tc", 32'(tc), 32'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
